// File: rtl/fir_out_requant_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_requant_fifo_if
// Description : Sample-path bundle for fir_out_requant_fifo: the FIR result
//               strobe going in and the valid/ready sample stream going out.
//               'master' is the environment side (FIR + consumer), 'slave'
//               is the re-quantizer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_out_requant_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SUM_WIDTH  = 19
) ();
    logic [SUM_WIDTH-1:0]  i_sum;
    logic                  i_sum_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output i_sum,
        output i_sum_valid,
        output i_ready,
        input  o_data,
        input  o_valid
    );

    modport slave (
        input  i_sum,
        input  i_sum_valid,
        input  i_ready,
        output o_data,
        output o_valid
    );
endinterface
`default_nettype wire

// File: rtl/fir_out_requant_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_requant_fifo
// Description : Re-quantizes wide FIR accumulator results to the sample width
//               (arithmetic shift, optional rounding, saturation), buffers
//               them in a first-word fall-through FIFO and hands them to a
//               backpressuring consumer over valid/ready.
//               Build option: define FIR_OUT_ROUND_EN to round half toward
//               +inf before the shift; otherwise the shift truncates (floor).
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_requant_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int SUM_WIDTH  = 19,
    parameter int OUT_SHIFT  = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  wire                           clk,
    input  wire                           reset_n,
    fir_out_requant_fifo_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_drop,
    output logic [CNT_WIDTH-1:0]          o_sat_count,
    input  wire                           i_clear
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    // One guard bit above the accumulator keeps the rounding add from wrapping.
    localparam int EXT = SUM_WIDTH + 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic signed [EXT-1:0] SAT_MAX =
        {{(EXT-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EXT-1:0] SAT_MIN =
        {{(EXT-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

`ifdef FIR_OUT_ROUND_EN
    localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [EXT-1:0] RND_ADD =
        (OUT_SHIFT > 0) ? (EXT'(1) << RND_POS) : EXT'(0);
`endif

    // Re-quantizer datapath
    logic signed [EXT-1:0]   sum_ext;
    logic signed [EXT-1:0]   sum_rnd;
    logic signed [EXT-1:0]   sum_shr;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [DATA_WIDTH-1:0]   sat_data;

    // Stage Q
    logic                    q_valid;
    logic [DATA_WIDTH-1:0]   q_data;
    logic                    q_sat;

    // FIFO
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    nonempty;
    logic                    push;
    logic                    pop;

    // Sign-extend, optionally round, shift and clamp the incoming accumulator.
    always_comb begin
        sum_ext = {bus.i_sum[SUM_WIDTH-1], bus.i_sum};
`ifdef FIR_OUT_ROUND_EN
        sum_rnd = sum_ext + RND_ADD;
`else
        sum_rnd = sum_ext;
`endif
        sum_shr  = sum_rnd >>> OUT_SHIFT;
        sat_hi   = (sum_shr > SAT_MAX);
        sat_lo   = (sum_shr < SAT_MIN);
        sat_data = sum_shr[DATA_WIDTH-1:0];
        if (sat_hi) begin
            sat_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sat_lo) begin
            sat_data = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // Stage Q: capture the re-quantized word and its saturation flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_sat   <= 1'b0;
        end else if (i_clear) begin
            q_valid <= 1'b0;
        end else begin
            q_valid <= bus.i_sum_valid;
            if (bus.i_sum_valid) begin
                q_data <= sat_data;
                q_sat  <= sat_hi | sat_lo;
            end
        end
    end

    // Push/pop decisions; a full FIFO still accepts a word when it pops in the
    // same cycle. A handshake during clear is honoured but the data vanishes.
    always_comb begin
        nonempty = (count != '0);
        pop      = nonempty && bus.i_ready;
        push     = q_valid && !i_clear && ((count != FULL_COUNT) || pop);
        o_drop   = q_valid && !i_clear && !push;
    end

    // Storage array; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Saturation event counter, sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_sat_count <= '0;
        end else if (i_clear) begin
            o_sat_count <= '0;
        end else if (q_valid && q_sat && (o_sat_count != '1)) begin
            o_sat_count <= o_sat_count + CNT_WIDTH'(1);
        end
    end

    assign o_count     = count;
    assign bus.o_valid = nonempty;
    assign bus.o_data  = nonempty ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_requant_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_out_requant_fifo
// Description : Directed self-checking bench for fir_out_requant_fifo. Two
//               instances: OUT_SHIFT=0 (main paths) and OUT_SHIFT=2 (shift and
//               rounding). Honours FIR_OUT_ROUND_EN for expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_out_requant_fifo;

    localparam int DW = 16;
    localparam int SW = 19;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic clear0;
    logic clear2;

    logic [CW-1:0] count0;
    logic [CW-1:0] count2;
    logic          drop0;
    logic          drop2;
    logic [7:0]    sat0;
    logic [7:0]    sat2;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] rx0[$];
    logic [DW-1:0] rx2[$];

    fir_out_requant_fifo_if #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) bus0 ();
    fir_out_requant_fifo_if #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) bus2 ();

    fir_out_requant_fifo #(
        .DATA_WIDTH(DW), .SUM_WIDTH(SW), .OUT_SHIFT(0), .FIFO_DEPTH(4), .CNT_WIDTH(8)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave),
        .o_count(count0), .o_drop(drop0), .o_sat_count(sat0), .i_clear(clear0)
    );

    fir_out_requant_fifo #(
        .DATA_WIDTH(DW), .SUM_WIDTH(SW), .OUT_SHIFT(2), .FIFO_DEPTH(4), .CNT_WIDTH(8)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave),
        .o_count(count2), .o_drop(drop2), .o_sat_count(sat2), .i_clear(clear2)
    );

    always #5 clk = ~clk;

    // Record every completed transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus0.o_valid && bus0.i_ready) rx0.push_back(bus0.o_data);
        if (bus2.o_valid && bus2.i_ready) rx2.push_back(bus2.o_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus0.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b expected 0", bus0.o_valid); end
        n_cmp++; if (bus0.o_data !== 16'd0) begin n_err++; $display("FAIL reset_data got %0d expected 0", bus0.o_data); end
        n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d expected 0", count0); end
        n_cmp++; if (drop0 !== 1'b0) begin n_err++; $display("FAIL reset_drop got %0b expected 0", drop0); end
        n_cmp++; if (sat0 !== 8'd0) begin n_err++; $display("FAIL reset_sat got %0d expected 0", sat0); end
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bus0.i_ready = 1'b1;
        bus0.i_sum = 19'd1234;
        bus0.i_sum_valid = 1'b1;
        step();
        bus0.i_sum_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.o_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %0b expected 0", bus0.o_valid); end
        step();
        n_cmp++; if (bus0.o_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b expected 1", bus0.o_valid); end
        n_cmp++; if (bus0.o_data !== 16'd1234) begin n_err++; $display("FAIL basic_data got %0d expected 1234", bus0.o_data); end
        n_cmp++; if (count0 !== 3'd1) begin n_err++; $display("FAIL basic_count got %0d expected 1", count0); end
        step();
        n_cmp++; if (bus0.o_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_after got %0b expected 0", bus0.o_valid); end
        n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("FAIL basic_count_after got %0d expected 0", count0); end
    endtask

    task automatic test_saturation();
        int vals[3] = '{40000, -40000, 32767};
        int expv[3] = '{32767, -32768, 32767};
        bus0.i_ready = 1'b1;
        rx0.delete();
        for (int i = 0; i < 3; i++) begin
            bus0.i_sum = SW'(vals[i]);
            bus0.i_sum_valid = 1'b1;
            step();
        end
        bus0.i_sum_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (rx0.size() !== 3) begin n_err++; $display("FAIL sat_rx_size got %0d expected 3", rx0.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx0.size()) begin
                n_cmp++; if (rx0[i] !== DW'(expv[i])) begin n_err++; $display("FAIL sat_data[%0d] got %0d expected %0d", i, $signed(rx0[i]), expv[i]); end
            end
        end
        n_cmp++; if (sat0 !== 8'd2) begin n_err++; $display("FAIL sat_count got %0d expected 2", sat0); end
    endtask

    task automatic test_shift();
        int vals[2] = '{6, -6};
`ifdef FIR_OUT_ROUND_EN
        int expv[2] = '{2, -1};
`else
        int expv[2] = '{1, -2};
`endif
        bus2.i_ready = 1'b1;
        rx2.delete();
        for (int i = 0; i < 2; i++) begin
            bus2.i_sum = SW'(vals[i]);
            bus2.i_sum_valid = 1'b1;
            step();
        end
        bus2.i_sum_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (rx2.size() !== 2) begin n_err++; $display("FAIL shift_rx_size got %0d expected 2", rx2.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < rx2.size()) begin
                n_cmp++; if (rx2[i] !== DW'(expv[i])) begin n_err++; $display("FAIL shift_data[%0d] got %0d expected %0d", i, $signed(rx2[i]), expv[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int drops = 0;
        int drop_k = -1;
        bus0.i_ready = 1'b0;
        rx0.delete();
        for (int k = 0; k < 8; k++) begin
            if (k < 5) begin
                bus0.i_sum = SW'(10 + k);
                bus0.i_sum_valid = 1'b1;
            end else begin
                bus0.i_sum_valid = 1'b0;
            end
            step();
            if (drop0 === 1'b1) begin
                drops++;
                drop_k = k;
            end
        end
        n_cmp++; if (drops !== 1) begin n_err++; $display("FAIL bp_drop_pulses got %0d expected 1", drops); end
        n_cmp++; if (drop_k !== 4) begin n_err++; $display("FAIL bp_drop_cycle got %0d expected 4", drop_k); end
        n_cmp++; if (count0 !== 3'd4) begin n_err++; $display("FAIL bp_count got %0d expected 4", count0); end
        n_cmp++; if (bus0.o_data !== 16'd10) begin n_err++; $display("FAIL bp_head_stable got %0d expected 10", bus0.o_data); end
        bus0.i_ready = 1'b1;
        repeat (6) step();
        n_cmp++; if (rx0.size() !== 4) begin n_err++; $display("FAIL bp_rx_size got %0d expected 4", rx0.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rx0.size()) begin
                n_cmp++; if (rx0[i] !== DW'(10 + i)) begin n_err++; $display("FAIL bp_order[%0d] got %0d expected %0d", i, rx0[i], 10 + i); end
            end
        end
        n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("FAIL bp_drained_count got %0d expected 0", count0); end
    endtask

    task automatic test_full_pop();
        int expv[5] = '{20, 21, 22, 23, 99};
        bus0.i_ready = 1'b0;
        rx0.delete();
        for (int k = 0; k < 4; k++) begin
            bus0.i_sum = SW'(20 + k);
            bus0.i_sum_valid = 1'b1;
            step();
        end
        bus0.i_sum_valid = 1'b0;
        step();
        step();
        n_cmp++; if (count0 !== 3'd4) begin n_err++; $display("FAIL fp_full_count got %0d expected 4", count0); end
        bus0.i_sum = SW'(99);
        bus0.i_sum_valid = 1'b1;
        step();
        bus0.i_sum_valid = 1'b0;
        bus0.i_ready = 1'b1;
        #1;
        n_cmp++; if (drop0 !== 1'b0) begin n_err++; $display("FAIL fp_no_drop got %0b expected 0", drop0); end
        step();
        bus0.i_ready = 1'b0;
        n_cmp++; if (count0 !== 3'd4) begin n_err++; $display("FAIL fp_count_held got %0d expected 4", count0); end
        bus0.i_ready = 1'b1;
        repeat (6) step();
        n_cmp++; if (rx0.size() !== 5) begin n_err++; $display("FAIL fp_rx_size got %0d expected 5", rx0.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < rx0.size()) begin
                n_cmp++; if (rx0[i] !== DW'(expv[i])) begin n_err++; $display("FAIL fp_order[%0d] got %0d expected %0d", i, rx0[i], expv[i]); end
            end
        end
    endtask

    task automatic test_clear();
        bus0.i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus0.i_sum = SW'(30 + k);
            bus0.i_sum_valid = 1'b1;
            step();
        end
        bus0.i_sum_valid = 1'b0;
        step();
        n_cmp++; if (count0 !== 3'd3) begin n_err++; $display("FAIL clr_pre_count got %0d expected 3", count0); end
        n_cmp++; if (sat0 !== 8'd2) begin n_err++; $display("FAIL clr_pre_sat got %0d expected 2", sat0); end
        clear0 = 1'b1;
        bus0.i_sum = SW'(77);
        bus0.i_sum_valid = 1'b1;
        step();
        clear0 = 1'b0;
        bus0.i_sum_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.o_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got %0b expected 0", bus0.o_valid); end
        n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("FAIL clr_count got %0d expected 0", count0); end
        n_cmp++; if (sat0 !== 8'd0) begin n_err++; $display("FAIL clr_sat got %0d expected 0", sat0); end
        n_cmp++; if (drop0 !== 1'b0) begin n_err++; $display("FAIL clr_drop got %0b expected 0", drop0); end
        repeat (3) step();
        n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("FAIL clr_ignored_strobe got %0d expected 0", count0); end
        bus0.i_ready = 1'b1;
        rx0.delete();
        bus0.i_sum = SW'(55);
        bus0.i_sum_valid = 1'b1;
        step();
        bus0.i_sum_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (rx0.size() !== 1) begin n_err++; $display("FAIL clr_next_size got %0d expected 1", rx0.size()); end
        if (rx0.size() > 0) begin
            n_cmp++; if (rx0[0] !== 16'd55) begin n_err++; $display("FAIL clr_next_data got %0d expected 55", rx0[0]); end
        end
    endtask

    task automatic test_async_reset();
        int vals[3] = '{40000, 41, 42};
        bus0.i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus0.i_sum = SW'(vals[k]);
            bus0.i_sum_valid = 1'b1;
            step();
        end
        bus0.i_sum_valid = 1'b0;
        step();
        n_cmp++; if (count0 !== 3'd3) begin n_err++; $display("FAIL rst_pre_count got %0d expected 3", count0); end
        n_cmp++; if (sat0 !== 8'd1) begin n_err++; $display("FAIL rst_pre_sat got %0d expected 1", sat0); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus0.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b expected 0", bus0.o_valid); end
        n_cmp++; if (bus0.o_data !== 16'd0) begin n_err++; $display("FAIL rst_data got %0d expected 0", bus0.o_data); end
        n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d expected 0", count0); end
        n_cmp++; if (sat0 !== 8'd0) begin n_err++; $display("FAIL rst_sat got %0d expected 0", sat0); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        bus0.i_ready = 1'b1;
        rx0.delete();
        bus0.i_sum = SW'(56);
        bus0.i_sum_valid = 1'b1;
        step();
        bus0.i_sum_valid = 1'b0;
        repeat (4) step();
        n_cmp++; if (rx0.size() !== 1) begin n_err++; $display("FAIL rst_next_size got %0d expected 1", rx0.size()); end
        if (rx0.size() > 0) begin
            n_cmp++; if (rx0[0] !== 16'd56) begin n_err++; $display("FAIL rst_next_data got %0d expected 56", rx0[0]); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clear0 = 1'b0;
        clear2 = 1'b0;
        bus0.i_sum = '0;
        bus0.i_sum_valid = 1'b0;
        bus0.i_ready = 1'b0;
        bus2.i_sum = '0;
        bus2.i_sum_valid = 1'b0;
        bus2.i_ready = 1'b0;

        test_reset();
        test_basic();
        test_saturation();
        test_shift();
        test_backpressure();
        test_full_pop();
        test_clear();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
